stream_minmax_window: RTL and testbench
=======================================

Name: stream_minmax_window

Overview:
Sequential stage that sits directly upstream of the 2x8b combinational min/max arithmetic. It accepts a val/rdy stream of 8-bit samples and folds each sample into a running min/max through a 2-input min/max compare. After every NSAMPLES accepted samples, or after an early flush, it emits one window result on a val/rdy output. It is the windowed-reduction block used wherever the datapath needs a per-window range.

Parameters:
NSAMPLES, 4, samples per window; legal range 2..255.
CW, $clog2(NSAMPLES+1), derived localparam; width of the sample counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; asserted when 0.
in_val  input  1  input sample valid.
in_rdy  output  1  block can accept a sample.
in_data  input  8  input sample.
flush  input  1  close the current window early; ignored when count is 0.
out_val  output  1  window result valid.
out_rdy  input  1  consumer accepts the result.
out_min  output  8  window minimum.
out_max  output  8  window maximum.
out_cnt  output  CW  number of samples in the emitted window.

Behaviour:
- Handshakes:
  - Input transfer occurs on a rising edge when in_val && in_rdy.
  - Output transfer occurs when out_val && out_rdy.
  - in_rdy and out_val are pure functions of state, with no combinational path from in_val or out_rdy.
- FSM has two states, ACCUM and DONE.
- ACCUM:
  - in_rdy=1, out_val=0.
  - On a transfer with cnt==0: min=max=in_data.
  - On a transfer with cnt>0: min=min(min,in_data), max=max(max,in_data), using the compare sub-module.
  - cnt increments on every transfer.
  - Go to DONE when the transfer makes cnt==NSAMPLES.
  - Also go to DONE when flush=1 and (cnt>0 or a transfer occurs this cycle).
  - Flush together with a transfer: the sample is included, then the window closes.
  - Flush with cnt==0 and no transfer: ignored, stay in ACCUM.
- DONE:
  - in_rdy=0, out_val=1.
  - out_min, out_max and out_cnt are held stable until transfer.
  - flush is ignored.
  - On transfer: cnt cleared to 0, go to ACCUM.
- Latency:
  - The edge that accepts the last sample of a window makes out_val=1 on the next cycle.
  - The accept-to-DONE-to-ACCUM round trip gives a minimum of one idle input cycle per window.
- Comparison: unsigned 8-bit compare. Equal values leave min and max unchanged. No width growth.
- Reset, asynchronous:
  - State ACCUM, cnt=0, internal min/max regs 0.
  - out_min=out_max=0, out_cnt=0, out_val=0.
  - in_rdy=0 while reset=0.
  - Reset mid-window or in DONE discards all partial or pending results without emitting them.
- out_min, out_max and out_cnt are driven from the registers in every state; they are only meaningful when out_val=1.

Optional Feature:
STREAM_MINMAX_WINDOW_SIGNED_EN:
- When defined, all comparisons treat in_data as two's-complement signed; min/max follow signed order, so 8'h80 is the smallest value.
- When undefined, comparisons are unsigned, so 8'h80 > 8'h7F.
- No port or timing changes either way.

Decomposition:
- Shared package stream_minmax_pkg holds:
  - state enum typedef {ACCUM, DONE};
  - localparam DATA_W=8.
- One natural sub-module, minmax_cmp_2x8b: combinational, inputs a and b, outputs lo and hi. Signed compare is selected by the same macro.
- The FSM, counter and registers live in the top.

Test Plan:
- Reset, then 4 samples 5,3,9,3 with out_rdy=1 (NSAMPLES=4) -> out_val on the cycle after the 4th accept; min=3, max=9, cnt=4. One cycle later in_rdy=1 and cnt=0.
- Samples 10,20, then flush=1 with no in_val -> out min=10, max=20, cnt=2. Flush with cnt==0 and no in_val -> no output, state unchanged.
- Sample 7 with flush=1 in the same cycle -> out min=7, max=7, cnt=1.
- Full window, then hold out_rdy=0 for 3 cycles -> out_val stays 1, outputs stable, in_rdy=0, and in_val samples offered are not accepted. Release out_rdy -> a single transfer.
- Samples 8'h80,8'h7F,8'h01,8'hFF -> unsigned: min=01, max=FF. With STREAM_MINMAX_WINDOW_SIGNED_EN: min=80, max=7F.
- Reset asserted after 2 samples, then released; then 4 samples 1,2,3,4 -> no output for the aborted window; out min=1, max=4, cnt=4.

Source files
------------

// File: rtl/stream_minmax_pkg.sv
// -----------------------------------------------------------------------------
// stream_minmax_pkg
//
// Shared types and constants for the windowed min/max reduction stage.
//   state_e : window FSM states (ACCUM collects samples, DONE holds a result)
//   DATA_W  : sample width
// -----------------------------------------------------------------------------
package stream_minmax_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage : stream_minmax_pkg

// File: rtl/minmax_cmp_2x8b.sv
// -----------------------------------------------------------------------------
// minmax_cmp_2x8b
//
// Combinational 2-input min/max of two DATA_W-bit values.
//
// Ports:
//   a  : operand A
//   b  : operand B
//   lo : smaller of a and b (b when equal)
//   hi : larger of a and b  (a when equal)
//
// Configuration:
//   STREAM_MINMAX_WINDOW_SIGNED_EN : when defined, operands are compared as
//   two's-complement signed values (8'h80 is the smallest). Otherwise the
//   compare is unsigned (8'h80 > 8'h7F).
// -----------------------------------------------------------------------------
module minmax_cmp_2x8b
  import stream_minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic a_lt_b;

`ifdef STREAM_MINMAX_WINDOW_SIGNED_EN
  assign a_lt_b = $signed(a) < $signed(b);
`else
  assign a_lt_b = a < b;
`endif

  // On a tie both selections return the same value, so the choice of which
  // operand wins is irrelevant to the result.
  assign lo = a_lt_b ? a : b;
  assign hi = a_lt_b ? b : a;

endmodule : minmax_cmp_2x8b

// File: rtl/stream_minmax_window.sv
// -----------------------------------------------------------------------------
// stream_minmax_window
//
// Folds a val/rdy stream of DATA_W-bit samples into a running min/max and
// emits one result per window of NSAMPLES samples, or earlier on flush.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   in_val   : input sample valid
//   in_rdy   : block can accept a sample (high only in ACCUM, out of reset)
//   in_data  : input sample
//   flush    : close the current non-empty window early (ignored in DONE)
//   out_val  : window result valid (high only in DONE)
//   out_rdy  : consumer accepts the result
//   out_min  : window minimum
//   out_max  : window maximum
//   out_cnt  : samples in the window (running count while accumulating)
//
// Parameters:
//   NSAMPLES : samples per window, 2..255
//   CW       : counter width, derived
//
// Configuration:
//   STREAM_MINMAX_WINDOW_SIGNED_EN : signed compare (see minmax_cmp_2x8b).
// -----------------------------------------------------------------------------
module stream_minmax_window
  import stream_minmax_pkg::*;
#(
  parameter  int NSAMPLES = 4,
  localparam int CW       = $clog2(NSAMPLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CW-1:0]     out_cnt
);

  localparam logic [CW-1:0] CNT_FULL = CW'(NSAMPLES);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [DATA_W-1:0] min_q,   min_d;
  logic [DATA_W-1:0] max_q,   max_d;

  logic              in_xfer;
  logic              out_xfer;
  logic [CW-1:0]     cnt_inc;
  logic [DATA_W-1:0] cmp_min;
  logic [DATA_W-1:0] cmp_max;
  logic              unused_min_hi;
  logic              unused_max_lo;

  // ---------------------------------------------------------------------------
  // Compare units: one folds the sample into the minimum, the other into the
  // maximum. Operand order makes an equal sample keep the stored value.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] min_hi_nc;
  logic [DATA_W-1:0] max_lo_nc;

  minmax_cmp_2x8b u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .lo (cmp_min),
    .hi (min_hi_nc)
  );

  minmax_cmp_2x8b u_cmp_max (
    .a  (max_q),
    .b  (in_data),
    .lo (max_lo_nc),
    .hi (cmp_max)
  );

  assign unused_min_hi = ^min_hi_nc;
  assign unused_max_lo = ^max_lo_nc;

  // ---------------------------------------------------------------------------
  // Handshakes. in_rdy/out_val depend only on state (and reset for in_rdy), so
  // there is no combinational path from in_val or out_rdy.
  // ---------------------------------------------------------------------------
  assign in_rdy   = reset && (state_q == ACCUM);
  assign out_val  = (state_q == DONE);
  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;
  assign cnt_inc  = cnt_q + CW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;

    unique case (state_q)
      ACCUM: begin
        if (in_xfer) begin
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            // First sample of a window seeds both extremes.
            min_d = in_data;
            max_d = in_data;
          end else begin
            min_d = cmp_min;
            max_d = cmp_max;
          end
          // A flush in the same cycle includes this sample, then closes.
          if (cnt_inc == CNT_FULL || flush) begin
            state_d = DONE;
          end
        end else if (flush && cnt_q != '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Result registers hold through backpressure; flush has no effect.
        if (out_xfer) begin
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the min/max registers are reset too, so the result ports read a
  // defined 0 out of reset rather than whatever the flops powered up with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign out_min = min_q;
  assign out_max = max_q;
  assign out_cnt = cnt_q;

endmodule : stream_minmax_window

// File: tb/tb_stream_minmax_window.sv
module tb_stream_minmax_window;

  localparam int NS = 4;
  localparam int CW = $clog2(NS + 1);

`ifdef STREAM_MINMAX_WINDOW_SIGNED_EN
  localparam logic [7:0] MIX_MIN = 8'h80;
  localparam logic [7:0] MIX_MAX = 8'h7F;
`else
  localparam logic [7:0] MIX_MIN = 8'h01;
  localparam logic [7:0] MIX_MAX = 8'hFF;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [7:0]    in_data;
  logic          flush;
  logic          out_val;
  logic          out_rdy;
  logic [7:0]    out_min;
  logic [7:0]    out_max;
  logic [CW-1:0] out_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_minmax_window #(.NSAMPLES(NS)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .flush   (flush),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_min (out_min),
    .out_max (out_max),
    .out_cnt (out_cnt)
  );

  typedef struct {
    logic       in_val;
    logic [7:0] data;
    logic       flush;
    logic       out_rdy;
    logic       e_val;
    logic       e_rdy;
    int         e_cnt;
    logic       chk_mm;
    logic [7:0] e_min;
    logic [7:0] e_max;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic fl,
                              input logic ordy, input logic ev, input logic er,
                              input int ec, input logic cm, input logic [7:0] emn,
                              input logic [7:0] emx);
    vec_t v;
    v.in_val = iv; v.data = d; v.flush = fl; v.out_rdy = ordy;
    v.e_val = ev; v.e_rdy = er; v.e_cnt = ec; v.chk_mm = cm;
    v.e_min = emn; v.e_max = emx;
    return v;
  endfunction

  // Compares every observable output against the expected tuple; min/max are
  // only compared when chk_mm is set.
  task automatic check(input string name, input logic ev, input logic er, input int ec,
                       input logic cm, input logic [7:0] emn, input logic [7:0] emx);
    logic [7:0] gmn, gmx, wmn, wmx;
    gmn = cm ? out_min : 8'h00;
    gmx = cm ? out_max : 8'h00;
    wmn = cm ? emn : 8'h00;
    wmx = cm ? emx : 8'h00;
    n_vec++;
    if (out_val !== ev || in_rdy !== er || out_cnt !== CW'(ec) || gmn !== wmn || gmx !== wmx) begin
      n_fail++;
      $display("FAIL %s: got val=%b rdy=%b cnt=%0d min=%h max=%h, want val=%b rdy=%b cnt=%0d min=%h max=%h",
               name, out_val, in_rdy, out_cnt, gmn, gmx, ev, er, ec, wmn, wmx);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic fl, input logic ordy);
    in_val = iv; in_data = d; flush = fl; out_rdy = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_val = 1'b0; in_data = 8'h00; flush = 1'b0; out_rdy = 1'b0;

    // in_val, data, flush, out_rdy | val, rdy, cnt, chk_mm, min, max
    // Full window 5,3,9,3 (duplicate 3 leaves min unchanged).
    vecs.push_back(mk(1, 8'd5,  0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'd3,  0, 1, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 8'd9,  0, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 8'd3,  0, 1, 1, 0, 4, 1, 8'd3, 8'd9));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));
    // Early flush with no transfer.
    vecs.push_back(mk(1, 8'd10, 0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'd20, 0, 1, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 8'd0,  1, 1, 1, 0, 2, 1, 8'd10, 8'd20));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));
    // Flush on an empty window is ignored.
    vecs.push_back(mk(0, 8'd0,  1, 1, 0, 1, 0, 0, 0, 0));
    // Flush together with a sample: one-sample window.
    vecs.push_back(mk(1, 8'd7,  1, 1, 1, 0, 1, 1, 8'd7, 8'd7));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));
    // Backpressure: window 50,60,40,70, consumer stalls 3 cycles while
    // samples and a flush are offered; all must be ignored.
    vecs.push_back(mk(1, 8'd50, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'd60, 0, 0, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 8'd40, 0, 0, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 8'd70, 0, 0, 1, 0, 4, 1, 8'd40, 8'd70));
    vecs.push_back(mk(1, 8'd0,  0, 0, 1, 0, 4, 1, 8'd40, 8'd70));
    vecs.push_back(mk(1, 8'd0,  1, 0, 1, 0, 4, 1, 8'd40, 8'd70));
    vecs.push_back(mk(1, 8'hFF, 0, 0, 1, 0, 4, 1, 8'd40, 8'd70));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));
    // Sign-sensitive window.
    vecs.push_back(mk(1, 8'h80, 0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h7F, 0, 1, 0, 1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 1, 1, 0, 4, 1, MIX_MIN, MIX_MAX));
    vecs.push_back(mk(0, 8'd0,  0, 1, 0, 1, 0, 0, 0, 0));

    // Reset state, checked while reset is held and before any clock edge.
    #1;
    check("reset_async", 0, 0, 0, 1, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    check("reset_held", 0, 0, 0, 1, 8'h00, 8'h00);
    #1;
    reset = 1'b1;
    #1;
    check("reset_release", 0, 1, 0, 0, 8'h00, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].in_val, vecs[i].data, vecs[i].flush, vecs[i].out_rdy);
      check($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_rdy, vecs[i].e_cnt,
            vecs[i].chk_mm, vecs[i].e_min, vecs[i].e_max);
    end

    // Reset mid-window: the partial window 200,100 must be discarded.
    drive(1, 8'd200, 0, 1);
    drive(1, 8'd100, 0, 1);
    check("midwin_cnt2", 0, 1, 2, 0, 8'h00, 8'h00);
    in_val = 1'b0;
    reset  = 1'b0;
    #1;
    check("midwin_reset", 0, 0, 0, 1, 8'h00, 8'h00);
    drive(0, 8'd0, 0, 1);
    reset = 1'b1;
    drive(1, 8'd1, 0, 1);
    check("after_rst_s1", 0, 1, 1, 0, 8'h00, 8'h00);
    drive(1, 8'd2, 0, 1);
    drive(1, 8'd3, 0, 1);
    drive(1, 8'd4, 0, 0);
    check("after_rst_win", 1, 0, 4, 1, 8'd1, 8'd4);

    // Reset while a result is pending: out_val drops without a transfer.
    in_val = 1'b0;
    reset  = 1'b0;
    #1;
    check("done_reset", 0, 0, 0, 1, 8'h00, 8'h00);
    drive(0, 8'd0, 0, 1);
    reset = 1'b1;
    drive(0, 8'd0, 0, 1);
    check("done_reset_idle", 0, 1, 0, 0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_stream_minmax_window
